rf_dbg_reader: RTL
==================

Name: rf_dbg_reader

Overview:
- Debug readout engine for the read side of a TTA register file (1 write port, 1 read port, combinational read).
- On request, it first obtains the global lock so the core cannot write during the dump.
- It then walks an address range through the RF read port and streams each word, tagged with its index, to the debugger over a valid/ready interface.
- It sits between the debug interface and the RF read-port mux.

Parameters:
- data_width_g, 32, RF word width in bits.
- depth_g, 16, number of RF entries; at least 2.
- addr_width_g, 4, RF index width; must satisfy 2**addr_width_g >= depth_g, minimum 1.

Ports:
- clk  in  1  clock.
- rstx  in  1  reset, asynchronous, active-low.
- start_in  in  1  start a dump; sampled only in IDLE.
- abort_in  in  1  cancel the dump; honoured in every state except IDLE.
- first_in  in  addr_width_g  first index, sampled with start_in.
- last_in  in  addr_width_g  last index (inclusive), sampled with start_in.
- lock_req_out  out  1  request the core global lock.
- lock_ack_in  in  1  core is locked (glock active).
- rop_out  out  addr_width_g  RF read index.
- rload_out  out  1  RF read strobe.
- rdata_in  in  data_width_g  RF read data, combinational from rop_out.
- dout_data  out  data_width_g  captured word.
- dout_idx  out  addr_width_g  index of dout_data.
- dout_valid  out  1  stream valid.
- dout_ready  in  1  stream ready.
- busy_out  out  1  high in every state except IDLE.
- done_out  out  1  one-cycle pulse: range fully transferred.
- err_out  out  1  one-cycle pulse: illegal range rejected.

Behaviour:
- Reset values: all outputs 0; state IDLE; pointer, last register, data and index registers 0.
- FSM states are IDLE, LOCK, READ, PUSH and DONE. All transitions occur on the rising clk edge.
- IDLE:
  - On start_in=1 with first_in<=last_in<depth_g: latch first_in into ptr and last_in into last_r, then go to LOCK.
  - On start_in=1 with an illegal range: pulse err_out for 1 cycle, stay in IDLE, issue no lock request and no reads.
  - start_in is ignored in every state except IDLE.
- LOCK:
  - lock_req_out=1.
  - Wait for lock_ack_in=1, then go to READ.
  - No timeout; only abort_in exits LOCK early.
- READ:
  - Lasts exactly 1 cycle.
  - rop_out=ptr and rload_out=1.
  - At the edge: dout_data<=rdata_in, dout_idx<=ptr, dout_valid<=1, then go to PUSH.
- PUSH:
  - rload_out=0.
  - dout_data, dout_idx and dout_valid hold stable until dout_valid&dout_ready.
  - On handshake with ptr==last_r: dout_valid<=0, go to DONE.
  - On handshake with ptr!=last_r: ptr<=ptr+1, dout_valid<=0, go to READ.
  - Throughput: at most 1 word per 2 cycles.
- DONE:
  - Lasts 1 cycle. done_out=1, lock_req_out<=0 at the exit edge, then go to IDLE.
- lock_req_out is high from LOCK entry until the DONE/abort exit edge. It stays high through READ and PUSH even if lock_ack_in drops; a dropped ack is a system error and is not checked.
- rop_out holds the last driven index when not in READ. rload_out gates RF use.
- Abort:
  - abort_in=1 in LOCK, READ, PUSH or DONE gives, at the next edge: IDLE, dout_valid=0, lock_req_out=0, no done_out, and ptr is not advanced.
  - abort_in has priority over the handshake in the same cycle; the word counts as not delivered.
- Asynchronous reset mid-dump: immediate return to IDLE with all outputs 0, including lock_req_out.
- Single-entry range (first==last): exactly one word, then DONE.
- Full range 0..depth_g-1: ptr stops at last_r and never increments past it, so no wrap-around.
- Range check is compared at addr_width_g width; when depth_g<2**addr_width_g, indices >=depth_g are errors.

Decomposition:
- Shared package: FSM state encoding (3-bit constants IDLE=0, LOCK=1, READ=2, PUSH=3, DONE=4).
- The clogb2 helper function also belongs in the shared package, for callers deriving addr_width_g.
- No sub-module: single module with one sequential FSM/datapath process and a combinational output decode.

Test Plan:
- depth_g=16, RF preloaded with R[i]=0xA0+i; start with first=3, last=5; ack after 2 cycles; dout_ready=1 -> words (3,0xA3), (4,0xA4), (5,0xA5) on dout_idx/dout_data, then done_out pulses once and lock_req_out falls.
- first=7, last=7 with ready stalled 4 cycles -> dout_valid held, data 0xA7 stable; one word, then done_out.
- first=9, last=2 and first=0, last=16 (addr_width_g=5) -> err_out 1-cycle pulse each; lock_req_out and rload_out stay 0; busy_out stays 0.
- Range 0..15 with random dout_ready -> 16 words in index order, no duplicates; rload_out pulses exactly 16 times.
- abort_in asserted in the same cycle as the handshake of idx 4 (range 2..6) -> next cycle IDLE, dout_valid=0, lock_req_out=0, no done_out; a new start then succeeds.
- rstx pulled low during PUSH -> all outputs 0 asynchronously; after release, start_in with 0..1 completes normally.

Source files
------------

// File: rtl/rf_dbg_reader_pkg.sv
// Shared definitions for the register-file debug readout engine.
package rf_dbg_reader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOCK = 3'd1,
    ST_READ = 3'd2,
    ST_PUSH = 3'd3,
    ST_DONE = 3'd4
  } rf_dbg_state_t;

  // Bits needed to index 'value' entries; never returns less than 1.
  function automatic int unsigned clogb2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (((value - 1) >> i) != 0) res = i + 1;
    end
    return (res < 1) ? 1 : res;
  endfunction

endpackage

// File: rtl/rf_dbg_reader.sv
// Debug readout engine: locks the core, walks an RF index range through the
// read port and streams each word with its index over valid/ready.
module rf_dbg_reader
  import rf_dbg_reader_pkg::*;
#(
  parameter int data_width_g = 32,
  parameter int depth_g      = 16,
  parameter int addr_width_g = 4
) (
  input  logic                    clk,
  input  logic                    rstx,
  input  logic                    start_in,
  input  logic                    abort_in,
  input  logic [addr_width_g-1:0] first_in,
  input  logic [addr_width_g-1:0] last_in,
  output logic                    lock_req_out,
  input  logic                    lock_ack_in,
  output logic [addr_width_g-1:0] rop_out,
  output logic                    rload_out,
  input  logic [data_width_g-1:0] rdata_in,
  output logic [data_width_g-1:0] dout_data,
  output logic [addr_width_g-1:0] dout_idx,
  output logic                    dout_valid,
  input  logic                    dout_ready,
  output logic                    busy_out,
  output logic                    done_out,
  output logic                    err_out
);

  localparam logic [addr_width_g:0] LP_DEPTH = (addr_width_g + 1)'(depth_g);

  rf_dbg_state_t             r_state;
  rf_dbg_state_t             w_next;
  logic [addr_width_g-1:0]   r_ptr;
  logic [addr_width_g-1:0]   r_last;
  logic [addr_width_g-1:0]   r_rop;
  logic [addr_width_g-1:0]   r_idx;
  logic [data_width_g-1:0]   r_data;
  logic                      r_valid;
  logic                      r_err;
  logic                      w_legal;
  logic                      w_hs;
  logic                      w_at_last;

  assign w_legal   = (first_in <= last_in) && ({1'b0, last_in} < LP_DEPTH);
  assign w_hs      = r_valid && dout_ready;
  assign w_at_last = (r_ptr == r_last);

  // State register.
  always_ff @(posedge clk or negedge rstx) begin
    if (!rstx) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next-state decode; abort wins over the handshake in every non-idle state.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (start_in && w_legal) w_next = ST_LOCK;
      ST_LOCK: begin
        if (abort_in)         w_next = ST_IDLE;
        else if (lock_ack_in) w_next = ST_READ;
      end
      ST_READ: w_next = abort_in ? ST_IDLE : ST_PUSH;
      ST_PUSH: begin
        if (abort_in)  w_next = ST_IDLE;
        else if (w_hs) w_next = w_at_last ? ST_DONE : ST_READ;
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Range pointer, captured word/index, stream valid and error pulse.
  always_ff @(posedge clk or negedge rstx) begin
    if (!rstx) begin
      r_ptr   <= '0;
      r_last  <= '0;
      r_rop   <= '0;
      r_idx   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start_in) begin
            if (w_legal) begin
              r_ptr  <= first_in;
              r_last <= last_in;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        ST_READ: begin
          r_rop <= r_ptr;
          if (!abort_in) begin
            r_data  <= rdata_in;
            r_idx   <= r_ptr;
            r_valid <= 1'b1;
          end
        end
        ST_PUSH: begin
          if (abort_in) begin
            r_valid <= 1'b0;
          end else if (w_hs) begin
            r_valid <= 1'b0;
            // ptr parks on the last index, so a full-range dump never wraps.
            if (!w_at_last) r_ptr <= r_ptr + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Output decode; the read index holds its last driven value outside READ.
  always_comb begin
    lock_req_out = (r_state != ST_IDLE);
    busy_out     = (r_state != ST_IDLE);
    rload_out    = (r_state == ST_READ);
    rop_out      = (r_state == ST_READ) ? r_ptr : r_rop;
    done_out     = (r_state == ST_DONE) && !abort_in;
    err_out      = r_err;
    dout_data    = r_data;
    dout_idx     = r_idx;
    dout_valid   = r_valid;
  end

endmodule
